func_responder: RTL
===================

// Module: func_responder
// PURPOSE
//  Responder (DUT) side of the start_i/busy_o handshake driven by the BIST controller.
//  - Latches two operands on start_i and computes y = a*a + floor(sqrt(b)) over several cycles.
//  - Holds busy_o high while it works, then presents the result on y_bo.
//  - Drop-in target for the BIST LFSR/CRC loop and for the manual input path.
// PARAMETERS
//  WIDTH    8   operand width; must be even (sqrt runs WIDTH/2 iterations)
//  Y_WIDTH  24  result width; must be >= 2*WIDTH; result zero-extended
// PORTS
//  clk_i    in   1        clock; all state updates on rising edge
//  rst_i    in   1        asynchronous, active-low reset
//  a_bi     in   WIDTH    operand a (squared); sampled only on an accepted start
//  b_bi     in   WIDTH    operand b (integer square root); sampled only on an accepted start
//  start_i  in   1        request; accepted only when state==IDLE
//  y_bo     out  Y_WIDTH  result; holds the last completed value
//  busy_o   out  1        high from the accept edge until the result edge
// BEHAVIOUR
//  Reset (rst_i low, async): y_bo=0, busy_o=0, state=IDLE, all datapath regs=0.
//  Reset mid-operation aborts the op; no partial result is ever written to y_bo.
//  States and transitions:
//  - IDLE: on an edge with start_i=1, latch a_bi/b_bi, set busy_o=1, clear acc/root,
//    cnt=0, go to MUL. With start_i=0 stay in IDLE.
//  - MUL: shift-add square, one multiplier bit per cycle, LSB first.
//    acc += a<<cnt if a[cnt]; WIDTH cycles; then cnt=WIDTH/2-1 and go to SQRT.
//  - SQRT: bitwise isqrt, one root bit per cycle, MSB first.
//    trial = root | (1<<cnt); if trial*trial <= b then root = trial.
//    WIDTH/2 cycles; then go to ADD.
//  - ADD: y_bo = acc + root (zero-extended); busy_o=0; go to IDLE.
//  Latency: accept edge k -> busy_o=1 after k; y_bo valid and busy_o=0 after edge
//    k+1+WIDTH+WIDTH/2 (k+13 at default). busy_o is high for exactly 13 cycles at default.
//  Handshake:
//  - start_i while busy is ignored; operands are not re-sampled.
//  - A level start_i held high restarts on the first IDLE edge: busy_o is low for 1 cycle.
//  - The requester may sample busy_o any number of cycles after start.
//  - The requester sees busy_o=1 on the cycle after it drives start_i.
//  Arithmetic: no overflow at default (max 255*255+15 = 65040 < 2^16).
//    y_bo[Y_WIDTH-1:2*WIDTH] is always 0.
//  a_bi/b_bi changing during busy has no effect on the result.
//  y_bo changes only at the ADD edge or at reset.
// TESTING
//  1. Release reset, idle 5 cycles -> y_bo=0, busy_o=0 throughout.
//  2. a=3, b=16, start 1 cycle -> busy_o high for 13 cycles, then y_bo=13.
//  3. a=255, b=255 -> y_bo=65040; a=0, b=0 -> y_bo=0; a=12, b=2 -> y_bo=145.
//  4. a=5, b=9 started; change inputs to a=1, b=1 and pulse start_i at cycle 4 of busy
//     -> pulse ignored, y_bo=28, busy_o still falls at cycle 13.
//  5. rst_i low at cycle 6 of an op (a=10, b=100) -> busy_o=0 and y_bo=0 immediately (async).
//     New op a=2, b=4 after release -> y_bo=6.
//  6. start_i held high with a=4, b=1 -> results 17 repeat;
//     busy_o low exactly 1 cycle between ops.

Source files
------------

// File: rtl/func_responder.sv
// func_responder: start/busy responder computing y = a*a + floor(sqrt(b)) with a multi-cycle shift-add/isqrt datapath
module func_responder #(
    parameter int WIDTH   = 8,
    parameter int Y_WIDTH = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    input  logic               start_i,
    output logic [Y_WIDTH-1:0] y_bo,
    output logic               busy_o
);
    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] SQRT = 2'd2;
    localparam logic [1:0] ADD  = 2'd3;
    logic [1:0]         state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] part;
    logic [HW-1:0]      root;
    logic [HW-1:0]      trial;
    logic [WIDTH-1:0]   trial_sq;
    logic [CW-1:0]      cnt;
    always_comb begin
        part     = a_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0;
        trial    = root | (HW'(1) << cnt);
        trial_sq = WIDTH'(trial) * WIDTH'(trial);
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            root   <= '0;
            cnt    <= '0;
            y_bo   <= '0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    a_r    <= a_bi;
                    b_r    <= b_bi;
                    acc    <= '0;
                    root   <= '0;
                    cnt    <= '0;
                    busy_o <= 1'b1;
                    state  <= MUL;
                end
                MUL: begin
                    acc   <= acc + part;
                    cnt   <= (cnt == CW'(WIDTH - 1)) ? CW'(HW - 1) : cnt + CW'(1);
                    state <= (cnt == CW'(WIDTH - 1)) ? SQRT : MUL;
                end
                SQRT: begin
                    root  <= (trial_sq <= b_r) ? trial : root;
                    cnt   <= cnt - CW'(1);
                    state <= (cnt == '0) ? ADD : SQRT;
                end
                ADD: begin
                    y_bo   <= Y_WIDTH'(acc) + Y_WIDTH'(root);
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
